rs232_stream_tx: RTL and testbench

- Serial transmitter at the far end of the 32-bit stb/ack output stream that the user design drives for RS-232 transmit.
- Accepts one word per handshake and serialises bits [7:0] onto the UART TX line as 8N1 (start, 8 data bits LSB first, stop).
- Sits in the board top level between the user design's rs232_tx output stream and the FPGA TX pin.
- Single clock domain; no FIFO, so backpressure is applied through ack.

---
 rtl/rs232_stream_tx.sv | 181 ++++++++++++++++++
 tb/tb_rs232_stream_tx.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_stream_tx.sv
// rs232_stream_tx: serialises byte [7:0] of each accepted stream word onto a UART TX line.
// Latency: stb seen in cycle T -> ack in T+1 -> start bit on tx in T+2; frame is 10*DIVIDER cycles (11*DIVIDER with parity).
// Backpressure: no buffering; ack is only offered in IDLE, so a producer holding stb waits until the stop bit has finished.
//
// Ports:
//   clk             system clock, all logic on the rising edge
//   rst             synchronous active-high reset; abandons any frame in flight
//   input_data      stream word; only [7:0] is transmitted, [31:8] is ignored
//   input_data_stb  producer strobe, held while input_data is valid
//   input_data_ack  registered acknowledge; a word transfers on a cycle with stb && ack
//   tx              serial line, idle high
//
// Configuration:
//   RS232_STREAM_TX_PARITY_EN  when defined, an even-parity bit is sent between the last
//                              data bit and the stop bit (8E1). Undefined gives 8N1.
//
// DIVIDER = CLOCK_FREQUENCY / BAUD_RATE (truncated) must be at least 2.

module rs232_stream_tx #(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int BAUD_RATE       = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_data,
  input  logic        input_data_stb,
  output logic        input_data_ack,
  output logic        tx
);

  localparam int DIVIDER = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CNT_W   = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIVIDER - 1);

`ifdef RS232_STREAM_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             bit_end;

`ifdef RS232_STREAM_TX_PARITY_EN
  // Parity is computed once at capture, before the shift register is consumed.
  logic             parity;
`endif

  // Upper word bits carry nothing for this transmitter.
  logic unused_upper;
  assign unused_upper = ^input_data[31:8];

  // Last cycle of the current bit period.
  assign bit_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      tx             <= 1'b1;
      input_data_ack <= 1'b0;
      bit_cnt        <= '0;
      baud_cnt       <= '0;
      shift          <= '0;
`ifdef RS232_STREAM_TX_PARITY_EN
      parity         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (input_data_stb && input_data_ack) begin
            // Transfer: tx drops in the same edge, so the start bit is
            // already on the line in the first START cycle.
            shift          <= input_data[7:0];
`ifdef RS232_STREAM_TX_PARITY_EN
            parity         <= ^input_data[7:0];
`endif
            input_data_ack <= 1'b0;
            tx             <= 1'b0;
            state          <= START;
          end else if (input_data_stb) begin
            input_data_ack <= 1'b1;
          end else begin
            // Covers a producer withdrawing stb while ack is offered:
            // the offer is dropped and nothing is captured.
            input_data_ack <= 1'b0;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
`ifdef RS232_STREAM_TX_PARITY_EN
              tx    <= parity;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              // tx is registered, so present the next bit (shift[1])
              // at the same edge that retires the current one.
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

`ifdef RS232_STREAM_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (bit_end) begin
            // IDLE must see stb for a cycle before offering ack again,
            // which gives the fixed two-cycle idle gap between frames.
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state          <= IDLE;
          tx             <= 1'b1;
          input_data_ack <= 1'b0;
          baud_cnt       <= '0;
          bit_cnt        <= '0;
        end
      endcase
    end
  end

  // ack is only ever offered from IDLE and is a single-cycle pulse.
  ack_only_in_idle: assert property (@(posedge clk) disable iff (rst)
    input_data_ack |-> (state == IDLE));

  ack_single_cycle: assert property (@(posedge clk) disable iff (rst)
    input_data_ack |=> !input_data_ack);

endmodule

// File: tb/tb_rs232_stream_tx.sv
module tb_rs232_stream_tx;

  localparam int DIV = 16;
`ifdef RS232_STREAM_TX_PARITY_EN
  localparam int NB = 11;
  localparam int EXP_FRAMES = 9;
`else
  localparam int NB = 10;
  localparam int EXP_FRAMES = 7;
`endif
  localparam int FRAME = NB * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] input_data = 32'h0;
  logic        input_data_stb = 1'b0;
  logic        input_data_ack;
  logic        tx;

  rs232_stream_tx #(
    .CLOCK_FREQUENCY(16),
    .BAUD_RATE      (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .input_data    (input_data),
    .input_data_stb(input_data_stb),
    .input_data_ack(input_data_ack),
    .tx            (tx)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int   cyc = 0;
  logic rst_seen = 1'b1;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  // ack pulse bookkeeping
  int   ack_rises = 0;
  int   ack_double = 0;
  logic ack_prev = 1'b0;
  always @(negedge clk) begin
    if (input_data_ack === 1'b1 && ack_prev !== 1'b1) ack_rises++;
    if (input_data_ack === 1'b1 && ack_prev === 1'b1) ack_double++;
    ack_prev = input_data_ack;
  end

  // Scoreboard: bytes pushed when a word is driven, popped at each start bit.
  logic [7:0] exp_q[$];

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef RS232_STREAM_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Line monitor: checks every cycle of every frame against the expected byte.
  int         mon_frames = 0;
  int         mon_cnt = 0;
  bit         mon_busy = 1'b0;
  bit         mon_ok = 1'b1;
  logic [7:0] mon_exp = 8'h0;
  logic [7:0] mon_dec = 8'h0;
  int         mon_k;
  always @(negedge clk) begin
    if (rst_seen === 1'b1) begin
      mon_busy = 1'b0;
    end else if (!mon_busy && tx === 1'b0) begin
      mon_busy = 1'b1;
      mon_cnt  = 0;
      mon_ok   = 1'b1;
      mon_dec  = 8'h0;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_frame: start bit at cycle %0d, scoreboard empty", cyc);
        mon_exp = 8'h00;
      end else begin
        mon_exp = exp_q.pop_front();
      end
    end
    if (mon_busy && rst_seen !== 1'b1) begin
      mon_k = mon_cnt / DIV;
      if (tx !== frame_bit(mon_exp, mon_k)) mon_ok = 1'b0;
      if ((mon_cnt % DIV) == DIV / 2 && mon_k >= 1 && mon_k <= 8) mon_dec[mon_k-1] = tx;
      if (mon_cnt == FRAME - 1) begin
        vectors++;
        if (!mon_ok || mon_dec !== mon_exp) begin
          miscompares++;
          $display("FAIL frame: decoded %02h line_ok=%0d, expected %02h line_ok=1", mon_dec, mon_ok, mon_exp);
        end
        mon_frames++;
        mon_busy = 1'b0;
      end else begin
        mon_cnt++;
      end
    end
  end

  // Drive a word and hold stb until the transfer edge. lat is the number of
  // cycles from stb raise to ack seen (-1 if ack never came). Returns at the
  // negedge after the transfer edge; stb is dropped there unless keep is set.
  task automatic send_word(input logic [31:0] w, input bit keep, output int lat);
    input_data     = w;
    input_data_stb = 1'b1;
    lat = -1;
    for (int i = 1; i <= 4 * FRAME; i++) begin
      @(negedge clk);
      if (input_data_ack === 1'b1) begin
        lat = i;
        break;
      end
    end
    if (lat >= 0) @(negedge clk);
    if (!keep || lat < 0) input_data_stb = 1'b0;
  endtask

  task automatic wait_frames(input int target, output bit ok);
    int n = 0;
    while (mon_frames < target && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    ok = (mon_frames >= target);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (tx !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_tx: got %b, expected 1", tx);
    end
    vectors++;
    if (input_data_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ack: got %b, expected 0", input_data_ack);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    int lat;
    int r0 = ack_rises;
    bit ok;
    int lows = 0;
    exp_q.push_back(8'h55);
    send_word(32'h0000_0055, 1'b0, lat);
    vectors++;
    if (lat !== 1) begin
      miscompares++;
      $display("FAIL single_ack_latency: got %0d, expected 1", lat);
    end
    vectors++;
    if (tx !== 1'b0 || input_data_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL single_start_edge: tx=%b ack=%b, expected tx=0 ack=0", tx, input_data_ack);
    end
    wait_frames(1, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL single_frame_timeout: frames=%0d, expected 1", mon_frames);
    end
    repeat (8) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    vectors++;
    if (lows != 0) begin
      miscompares++;
      $display("FAIL single_idle_high: %0d low cycles after frame, expected 0", lows);
    end
    vectors++;
    if (ack_rises - r0 != 1) begin
      miscompares++;
      $display("FAIL single_ack_pulses: got %0d, expected 1", ack_rises - r0);
    end
  endtask

  task automatic test_upper_bits;
    int lat;
    bit ok;
    exp_q.push_back(8'h00);
    send_word(32'hFFFF_FF00, 1'b0, lat);
    vectors++;
    if (lat !== 1) begin
      miscompares++;
      $display("FAIL upper_ack_latency: got %0d, expected 1", lat);
    end
    wait_frames(2, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL upper_frame_timeout: frames=%0d, expected 2", mon_frames);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat1, lat2, c1, c2;
    int r0 = ack_rises;
    bit ok;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    send_word(32'h0000_00A5, 1'b1, lat1);
    c1 = cyc;
    send_word(32'h0000_003C, 1'b0, lat2);
    c2 = cyc;
    vectors++;
    if (c2 - c1 != FRAME + 2) begin
      miscompares++;
      $display("FAIL b2b_start_spacing: got %0d cycles, expected %0d", c2 - c1, FRAME + 2);
    end
    wait_frames(4, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL b2b_frame_timeout: frames=%0d, expected 4", mon_frames);
    end
    vectors++;
    if (ack_rises - r0 != 2) begin
      miscompares++;
      $display("FAIL b2b_ack_pulses: got %0d, expected 2", ack_rises - r0);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_backpressure;
    int lat;
    int highs = 0;
    bit ok;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    send_word(32'h0000_0012, 1'b1, lat);
    input_data = 32'h0000_0034;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (input_data_ack !== 1'b0) highs++;
    end
    vectors++;
    if (highs != 0) begin
      miscompares++;
      $display("FAIL bp_ack_in_frame: ack high %0d cycles, expected 0", highs);
    end
    @(negedge clk);
    vectors++;
    if (input_data_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_ack_after_stop: got %b, expected 1", input_data_ack);
    end
    @(negedge clk);
    vectors++;
    if (tx !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_second_start: tx=%b, expected 0", tx);
    end
    input_data_stb = 1'b0;
    wait_frames(6, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL bp_frame_timeout: frames=%0d, expected 6", mon_frames);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_midframe;
    int lat;
    int f0;
    bit ok;
    exp_q.push_back(8'hC3);
    send_word(32'h0000_00C3, 1'b0, lat);
    f0 = mon_frames;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (tx !== 1'b1 || input_data_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_first_edge: tx=%b ack=%b, expected tx=1 ack=0", tx, input_data_ack);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (tx !== 1'b1 || input_data_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_held: tx=%b ack=%b, expected tx=1 ack=0", tx, input_data_ack);
    end
    exp_q.push_back(8'h5A);
    send_word(32'h0000_005A, 1'b0, lat);
    vectors++;
    if (lat !== 1) begin
      miscompares++;
      $display("FAIL midreset_next_latency: got %0d, expected 1", lat);
    end
    vectors++;
    if (mon_frames != f0) begin
      miscompares++;
      $display("FAIL midreset_aborted: frames=%0d, expected %0d", mon_frames, f0);
    end
    wait_frames(f0 + 1, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL midreset_frame_timeout: frames=%0d, expected %0d", mon_frames, f0 + 1);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_abort;
    int lows = 0;
    int f0 = mon_frames;
    input_data     = 32'h0000_0077;
    input_data_stb = 1'b1;
    @(negedge clk);
    vectors++;
    if (input_data_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_ack_offer: got %b, expected 1", input_data_ack);
    end
    input_data_stb = 1'b0;
    @(negedge clk);
    vectors++;
    if (input_data_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_ack_drop: got %b, expected 0", input_data_ack);
    end
    repeat (3 * DIV) begin
      if (tx !== 1'b1) lows++;
      @(negedge clk);
    end
    vectors++;
    if (lows != 0 || mon_frames != f0) begin
      miscompares++;
      $display("FAIL abort_no_frame: low=%0d frames=%0d, expected low=0 frames=%0d", lows, mon_frames, f0);
    end
  endtask

`ifdef RS232_STREAM_TX_PARITY_EN
  task automatic test_parity;
    int lat, c1, c2;
    bit ok;
    int f0 = mon_frames;
    exp_q.push_back(8'h07);
    exp_q.push_back(8'h00);
    send_word(32'h0000_0007, 1'b1, lat);
    c1 = cyc;
    input_data = 32'h0000_0000;
    repeat (9 * DIV + DIV / 2) @(negedge clk);
    vectors++;
    if (tx !== 1'b1) begin
      miscompares++;
      $display("FAIL parity_bit: got %b, expected 1", tx);
    end
    send_word(32'h0000_0000, 1'b0, lat);
    c2 = cyc;
    vectors++;
    if (c2 - c1 != 11 * DIV + 2) begin
      miscompares++;
      $display("FAIL parity_frame_spacing: got %0d, expected %0d", c2 - c1, 11 * DIV + 2);
    end
    wait_frames(f0 + 2, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL parity_frame_timeout: frames=%0d, expected %0d", mon_frames, f0 + 2);
    end
    repeat (3) @(negedge clk);
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_upper_bits();
    test_back_to_back();
    test_backpressure();
    test_reset_midframe();
    test_abort();
`ifdef RS232_STREAM_TX_PARITY_EN
    test_parity();
`endif
    repeat (4) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d words left, expected 0", exp_q.size());
    end
    vectors++;
    if (mon_frames != EXP_FRAMES) begin
      miscompares++;
      $display("FAIL frame_count: got %0d, expected %0d", mon_frames, EXP_FRAMES);
    end
    vectors++;
    if (ack_double != 0) begin
      miscompares++;
      $display("FAIL ack_width: %0d back-to-back ack cycles, expected 0", ack_double);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
